// File: rtl/ref_seq_reader.sv
// ref_seq_reader: DRAM reference reader. Accepts (address, block count)
// requests, issues DRAM word reads under a credit limit, packs returned
// words LSW-first into 2*REF_LENGTH-bit blocks and streams them out through
// a small FIFO with a valid/rdy handshake.
// Optional feature: define REF_SEQ_READER_PERF_EN to add a 32-bit
// saturating counter of output stall cycles (perf_stall_cycles_out).
//
// Handshakes: a block moves when ref_seq_block_valid_out && ref_seq_block_rdy_in;
// a DRAM read is taken when dram_rd_req_out && dram_rd_gnt_in, and req/addr
// hold steady until then; returned words have no backpressure.
module ref_seq_reader #(
    parameter int REF_LENGTH = 128,
    parameter int DRAM_WIDTH = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [24:0]             ref_addr_in,
    input  logic [24:0]             ref_length_in,
    input  logic                    ref_info_valid_in,
    output logic                    ref_info_rdy_out,
    output logic [24:0]             dram_rd_addr_out,
    output logic                    dram_rd_req_out,
    input  logic                    dram_rd_gnt_in,
    input  logic [DRAM_WIDTH-1:0]   dram_rd_data_in,
    input  logic                    dram_rd_data_valid_in,
    output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
    output logic                    ref_seq_block_valid_out,
    input  logic                    ref_seq_block_rdy_in,
    output logic                    ref_seq_block_last_out,
    output logic                    ref_done_out,
    output logic                    overrun_err_out
`ifdef REF_SEQ_READER_PERF_EN
    ,
    output logic [31:0]             perf_stall_cycles_out
`endif
);

    localparam int BW   = 2 * REF_LENGTH;
    localparam int WPB  = BW / DRAM_WIDTH;
    localparam int CMAX = FIFO_DEPTH * WPB;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WCW  = 26 + $clog2(WPB);
    localparam int ACW  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [24:0]     r_addr;
    logic [WCW-1:0]  r_words_to_req;
    logic [24:0]     r_blocks_left;
    logic [CW-1:0]   r_inflight;
    logic [BW-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last_mem;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overrun;

    logic            w_accept;
    logic            w_grant;
    logic            w_ret;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_valid;
    logic            w_credit_ok;
    logic [CW-1:0]   w_used;
    logic [ACW-1:0]  w_asm_cnt;
    logic [BW-1:0]   w_push_block;

    assign w_accept     = ref_info_valid_in && (r_state == S_IDLE);
    assign w_grant      = dram_rd_req_out && dram_rd_gnt_in;
    // A return with nothing in flight is stale/spurious and is dropped.
    assign w_ret        = dram_rd_data_valid_in && (r_inflight != '0);
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && ref_seq_block_rdy_in;
    // Every word is either in flight, in the assembler or in the FIFO, so
    // capping their sum at the FIFO capacity makes overflow impossible.
    assign w_used       = r_inflight + CW'(r_count) * CW'(WPB) + CW'(w_asm_cnt);
    assign w_credit_ok  = (w_used < CW'(CMAX));

    generate
        if (WPB == 1) begin : g_direct
            assign w_asm_cnt    = '0;
            assign w_push       = w_ret;
            assign w_push_block = dram_rd_data_in;
        end else begin : g_asm
            logic [ACW-1:0] r_asm_cnt;
            logic [BW-1:0]  r_asm_data;
            // Collect words LSW first; the final word bypasses the register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_asm_cnt  <= '0;
                    r_asm_data <= '0;
                end else if (w_ret) begin
                    r_asm_data[r_asm_cnt*DRAM_WIDTH +: DRAM_WIDTH] <= dram_rd_data_in;
                    r_asm_cnt <= (r_asm_cnt == ACW'(WPB - 1)) ? '0 : r_asm_cnt + 1'b1;
                end
            end
            assign w_asm_cnt    = r_asm_cnt;
            assign w_push       = w_ret && (r_asm_cnt == ACW'(WPB - 1));
            assign w_push_block = {dram_rd_data_in, r_asm_data[BW-DRAM_WIDTH-1:0]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and FSM-decoded outputs.
    always_comb begin
        w_state_nxt      = r_state;
        ref_info_rdy_out = 1'b0;
        dram_rd_req_out  = 1'b0;
        ref_done_out     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ref_info_rdy_out = rst_n;
                if (ref_info_valid_in)
                    w_state_nxt = (ref_length_in == '0) ? S_DRAIN : S_FETCH;
            end
            S_FETCH: begin
                dram_rd_req_out = (r_words_to_req != '0) && w_credit_ok;
                if (w_grant && (r_words_to_req == WCW'(1)))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_inflight == '0) && (w_asm_cnt == '0) &&
                    ((r_count == '0) || ((r_count == (AW+1)'(1)) && w_pop))) begin
                    ref_done_out = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request bookkeeping, outstanding-read count and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_words_to_req <= '0;
            r_blocks_left  <= '0;
            r_inflight     <= '0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr         <= ref_addr_in;
                r_words_to_req <= WCW'(ref_length_in) * WCW'(WPB);
            end else if (w_grant) begin
                r_addr         <= r_addr + 25'd1;
                r_words_to_req <= r_words_to_req - WCW'(1);
            end
            if (w_accept)    r_blocks_left <= ref_length_in;
            else if (w_push) r_blocks_left <= r_blocks_left - 25'd1;
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_ret);
            if ((ref_info_valid_in && (r_state != S_IDLE)) ||
                (dram_rd_data_valid_in && (r_inflight == '0)))
                r_overrun <= 1'b1;
        end
    end

    // FIFO pointers, occupancy and per-entry last tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_mem <= '0;
        end else begin
            if (w_push) begin
                r_last_mem[r_wr_ptr] <= (r_blocks_left == 25'd1);
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // FIFO storage; read side is gated by valid so it never shows stale data.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_block;
    end

    assign dram_rd_addr_out        = r_addr;
    assign ref_seq_block_valid_out = w_fifo_valid;
    assign ref_seq_block_out       = w_fifo_valid ? r_mem[r_rd_ptr] : '0;
    assign ref_seq_block_last_out  = w_fifo_valid && r_last_mem[r_rd_ptr];
    assign overrun_err_out         = r_overrun;

`ifdef REF_SEQ_READER_PERF_EN
    logic [31:0] r_perf;
    // Saturating count of cycles a block waits on the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perf <= '0;
        else if (w_accept)
            r_perf <= '0;
        else if (w_fifo_valid && !ref_seq_block_rdy_in && (r_perf != 32'hFFFF_FFFF))
            r_perf <= r_perf + 32'd1;
    end
    assign perf_stall_cycles_out = r_perf;
`endif

endmodule

// File: tb/tb_ref_seq_reader.sv
// Bench for ref_seq_reader: u_dut1 uses the default WPB=1 build and is
// checked every cycle against a queue-based model; u_dut2 uses
// DRAM_WIDTH=128 (WPB=2) for the address-wrap / assembly case.
module tb_ref_seq_reader;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT1 (WPB=1)
  logic [24:0]  addr_in, len_in;
  logic         info_valid, info_rdy;
  logic [24:0]  rd_addr;
  logic         rd_req, gnt, rd_dv;
  logic [255:0] rd_data, blk;
  logic         blk_valid, blk_rdy, blk_last, done, err;
`ifdef REF_SEQ_READER_PERF_EN
  logic [31:0]  perf;
`endif

  // DUT2 (WPB=2)
  logic [24:0]  addr_in2, len_in2, rd_addr2;
  logic         info_valid2, info_rdy2, rd_req2, gnt2, rd_dv2;
  logic [127:0] rd_data2;
  logic [255:0] blk2;
  logic         blk_valid2, blk_rdy2, blk_last2, done2, err2;
`ifdef REF_SEQ_READER_PERF_EN
  logic [31:0]  perf2;
`endif

  ref_seq_reader u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ref_addr_in(addr_in), .ref_length_in(len_in),
    .ref_info_valid_in(info_valid), .ref_info_rdy_out(info_rdy),
    .dram_rd_addr_out(rd_addr), .dram_rd_req_out(rd_req), .dram_rd_gnt_in(gnt),
    .dram_rd_data_in(rd_data), .dram_rd_data_valid_in(rd_dv),
    .ref_seq_block_out(blk), .ref_seq_block_valid_out(blk_valid),
    .ref_seq_block_rdy_in(blk_rdy), .ref_seq_block_last_out(blk_last),
    .ref_done_out(done), .overrun_err_out(err)
`ifdef REF_SEQ_READER_PERF_EN
    , .perf_stall_cycles_out(perf)
`endif
  );

  ref_seq_reader #(.REF_LENGTH(128), .DRAM_WIDTH(128), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .ref_addr_in(addr_in2), .ref_length_in(len_in2),
    .ref_info_valid_in(info_valid2), .ref_info_rdy_out(info_rdy2),
    .dram_rd_addr_out(rd_addr2), .dram_rd_req_out(rd_req2), .dram_rd_gnt_in(gnt2),
    .dram_rd_data_in(rd_data2), .dram_rd_data_valid_in(rd_dv2),
    .ref_seq_block_out(blk2), .ref_seq_block_valid_out(blk_valid2),
    .ref_seq_block_rdy_in(blk_rdy2), .ref_seq_block_last_out(blk_last2),
    .ref_done_out(done2), .overrun_err_out(err2)
`ifdef REF_SEQ_READER_PERF_EN
    , .perf_stall_cycles_out(perf2)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
  endtask

  // DRAM word contents: each 32-bit lane carries its lane index and the address.
  function automatic logic [255:0] word1_of(input logic [24:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = {4'(k), 3'b000, a};
    return w;
  endfunction

  function automatic logic [127:0] word2_of(input logic [24:0] a);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = {4'(k), 3'b000, a};
    return w;
  endfunction

  // ---------------- model state ----------------
  logic [24:0]  exp_addr_q[$];
  logic [255:0] exp_q[$];
  logic         exp_last_q[$];
  int           exp_done_pending;
  logic         exp_rdy;
  logic         chk_en;
  int           cyc, grants, pops, dones, strobe_cyc, done_cyc;
  logic [24:0]  got_addr[$];
  logic [255:0] got_blk[$];
  int           got_gcyc[$];
  logic         prev_req_wait, prev_hold;
  logic [24:0]  prev_addr;
  logic [255:0] prev_blk;

  // ---------------- DRAM responders (zero-wait grant, 1-cycle return) ----------------
  logic        gnt_en, spur, pend1, pend2;
  logic [24:0] pend_addr1, pend_addr2;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend1 = 1'b0; rd_dv = 1'b0; rd_data = '0; gnt = 1'b0;
      pend2 = 1'b0; rd_dv2 = 1'b0; rd_data2 = '0; gnt2 = 1'b0;
    end else begin
      rd_dv = pend1;
      rd_data = pend1 ? word1_of(pend_addr1) : '0;
      if (spur && !pend1) begin
        rd_dv = 1'b1;
        rd_data = '1;
        spur = 1'b0;
      end
      gnt = gnt_en;
      pend1 = gnt && rd_req;
      pend_addr1 = rd_addr;
      rd_dv2 = pend2;
      rd_data2 = pend2 ? word2_of(pend_addr2) : '0;
      gnt2 = 1'b1;
      pend2 = gnt2 && rd_req2;
      pend_addr2 = rd_addr2;
    end
  end

  // ---------------- compare process for u_dut1 ----------------
  always @(negedge clk) begin
    #2;
    cyc++;
    if (chk_en && rst_n) begin
      check("info_rdy", info_rdy, exp_rdy);
      if (info_valid && info_rdy) strobe_cyc = cyc;
      if (prev_req_wait) begin
        check("req_held", rd_req, 1'b1);
        check("addr_held", rd_addr, prev_addr);
      end
      if (prev_hold) begin
        check("valid_held", blk_valid, 1'b1);
        check("blk_held", blk, prev_blk);
      end
      if (rd_req && gnt) begin
        grants++;
        got_addr.push_back(rd_addr);
        got_gcyc.push_back(cyc);
        if (exp_addr_q.size() == 0) fail("unexpected_grant", rd_addr, 0);
        else check("grant_addr", rd_addr, exp_addr_q.pop_front());
      end
      if (blk_valid && blk_rdy) begin
        pops++;
        got_blk.push_back(blk);
        if (exp_q.size() == 0) fail("unexpected_block", blk, 0);
        else begin
          check("blk_data", blk, exp_q.pop_front());
          check("blk_last", blk_last, exp_last_q.pop_front());
        end
      end
      check("occupancy_le_depth", ((grants - pops) <= FD), 1'b1);
      if (done) begin
        dones++;
        done_cyc = cyc;
        if (exp_done_pending == 0) fail("unexpected_done", done, 0);
        else begin
          exp_done_pending--;
          check("done_all_delivered", (exp_q.size() == 0) && (exp_addr_q.size() == 0), 1'b1);
        end
        exp_rdy = 1'b1;
      end
      prev_req_wait = rd_req && !gnt;
      prev_addr = rd_addr;
      prev_hold = blk_valid && !blk_rdy;
      prev_blk = blk;
    end else begin
      prev_req_wait = 1'b0;
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [24:0] a, input logic [24:0] n);
    @(posedge clk); #1;
    addr_in = a;
    len_in = n;
    info_valid = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(a + 25'(i));
      exp_q.push_back(word1_of(a + 25'(i)));
      exp_last_q.push_back(i == int'(n) - 1);
    end
    exp_done_pending++;
    @(posedge clk); #1;
    info_valid = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic raw_strobe(input logic [24:0] a, input logic [24:0] n);
    @(posedge clk); #1;
    addr_in = a;
    len_in = n;
    info_valid = 1'b1;
    @(posedge clk); #1;
    info_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (((exp_done_pending != 0) || !info_rdy) && (n < max)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= max) fail("wait_done_timeout", n, max);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("rst_info_rdy", info_rdy, 1'b0);
    check("rst_req", rd_req, 1'b0);
    check("rst_addr", rd_addr, 25'd0);
    check("rst_valid", blk_valid, 1'b0);
    check("rst_blk", blk, '0);
    check("rst_last", blk_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_info_rdy", info_rdy, 1'b1);
    check("post_rst_req", rd_req, 1'b0);
    check("post_rst_valid", blk_valid, 1'b0);
    exp_addr_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    exp_done_pending = 0;
    exp_rdy = 1'b1;
    grants = 0;
    pops = 0;
    chk_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int g0, p0, d0, n;
    logic [24:0]  g2_addr[$];
    logic [255:0] b2;
    logic         l2;
    int           d2;
    rst_n = 1'b0;
    addr_in = '0; len_in = '0; info_valid = 1'b0; blk_rdy = 1'b1;
    addr_in2 = '0; len_in2 = '0; info_valid2 = 1'b0; blk_rdy2 = 1'b1;
    gnt_en = 1'b1; spur = 1'b0;
    chk_en = 1'b0; exp_rdy = 1'b1; exp_done_pending = 0;
    cyc = 0; grants = 0; pops = 0; dones = 0; strobe_cyc = 0; done_cyc = 0;
    prev_req_wait = 1'b0; prev_hold = 1'b0; prev_addr = '0; prev_blk = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic read: 3 blocks from 0x100.
    got_addr.delete(); got_blk.delete(); got_gcyc.delete();
    d0 = dones;
    start_req(25'h100, 25'd3);
    wait_done(50);
    check("basic_grants", got_addr.size(), 3);
    check("basic_blocks", got_blk.size(), 3);
    if (got_addr.size() == 3) begin
      check("basic_addr0", got_addr[0], 25'h100);
      check("basic_addr2", got_addr[2], 25'h102);
      check("basic_first_req_lat", got_gcyc[0] - strobe_cyc, 1);
      check("basic_back_to_back", got_gcyc[2] - got_gcyc[0], 2);
    end
    if (got_blk.size() == 3) begin
      check("basic_blk0_lane0", got_blk[0][31:0], 32'h0000_0100);
      check("basic_blk2_lane1", got_blk[2][63:32], 32'h1000_0102);
    end
    check("basic_done_lat", done_cyc - strobe_cyc, 5);
    check("basic_done_once", dones - d0, 1);
    check("basic_rdy_back", info_rdy, 1'b1);

    // Length 0: done one cycle after the strobe, no reads, no blocks.
    g0 = grants; p0 = pops; d0 = dones;
    start_req(25'h777, 25'd0);
    wait_done(20);
    check("len0_done_lat", done_cyc - strobe_cyc, 1);
    check("len0_no_reads", grants - g0, 0);
    check("len0_no_blocks", pops - p0, 0);
    check("len0_done_once", dones - d0, 1);

    // Backpressure: 10 blocks, engine stalls 50 cycles.
    blk_rdy = 1'b0;
    g0 = grants; p0 = pops;
    start_req(25'h200, 25'd10);
    repeat (50) @(posedge clk);
    #1;
    check("bp_grants_capped", grants - g0, 4);
    check("bp_req_low", rd_req, 1'b0);
    check("bp_valid", blk_valid, 1'b1);
    blk_rdy = 1'b1;
    wait_done(200);
    check("bp_all_blocks", pops - p0, 10);

`ifdef REF_SEQ_READER_PERF_EN
    // Stall counter: exactly 7 stalled cycles.
    blk_rdy = 1'b0;
    start_req(25'h500, 25'd2);
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!blk_valid && (n < 100));
    if (n >= 100) fail("perf_valid_timeout", n, 100);
    repeat (7) @(posedge clk);
    #1;
    blk_rdy = 1'b1;
    wait_done(100);
    check("perf_stalls", perf, 32'd7);
    start_req(25'h600, 25'd1);
    wait_done(50);
    check("perf_cleared", perf, 32'd0);
`endif

    // Wrap and 2-word assembly on u_dut2.
    @(posedge clk); #1;
    addr_in2 = 25'h1FF_FFFF; len_in2 = 25'd1; info_valid2 = 1'b1;
    @(posedge clk); #1;
    info_valid2 = 1'b0;
    b2 = '0; l2 = 1'b0; d2 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #3;
      if (rd_req2 && gnt2) g2_addr.push_back(rd_addr2);
      if (blk_valid2 && blk_rdy2) begin
        b2 = blk2;
        l2 = blk_last2;
      end
      if (done2) d2++;
    end
    check("wrap_grants", g2_addr.size(), 2);
    if (g2_addr.size() == 2) begin
      check("wrap_addr0", g2_addr[0], 25'h1FF_FFFF);
      check("wrap_addr1", g2_addr[1], 25'h000_0000);
    end
    check("wrap_block", b2, {word2_of(25'h000_0000), word2_of(25'h1FF_FFFF)});
    check("wrap_w0_lane0", b2[31:0], 32'h01FF_FFFF);
    check("wrap_w0_lane1", b2[63:32], 32'h11FF_FFFF);
    check("wrap_w1_lane1", b2[191:160], 32'h1000_0000);
    check("wrap_last", l2, 1'b1);
    check("wrap_done_once", d2, 1);
    check("wrap_no_err", err2, 1'b0);
    check("wrap_rdy", info_rdy2, 1'b1);

    // Second strobe during FETCH is dropped and flags an error.
    check("err_clear_before", err, 1'b0);
    gnt_en = 1'b0;
    g0 = grants;
    start_req(25'h300, 25'd4);
    @(posedge clk); #1;
    raw_strobe(25'h555, 25'd7);
    check("err_dup_strobe", err, 1'b1);
    gnt_en = 1'b1;
    wait_done(100);
    check("err_dup_grants", grants - g0, 4);

    // Spurious DRAM data while idle.
    do_reset();
    p0 = pops;
    @(posedge clk); #1;
    spur = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("err_spurious", err, 1'b1);
    check("spurious_no_block", blk_valid, 1'b0);
    check("spurious_no_pop", pops - p0, 0);

    // Reset in the middle of a transfer, then a clean request.
    blk_rdy = 1'b0;
    start_req(25'h400, 25'd6);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", info_rdy, 1'b0);
    check("mid_valid", blk_valid, 1'b1);
    do_reset();
    check("mid_err_cleared", err, 1'b0);
    blk_rdy = 1'b1;
    start_req(25'h40, 25'd2);
    wait_done(50);
    check("after_rst_blocks", pops, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
